// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared constants, types and blanking rule for the hex display scanner
package hex_display_pkg;

  localparam int         DIGITS   = 4;
  localparam int         NIBBLE_W = 4;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  typedef logic [1:0] idx_t;

  typedef struct packed {
    logic [DIGITS*NIBBLE_W-1:0] value;
    logic [DIGITS-1:0]          dp;
  } frame_t;

  // A digit is a leading zero when it and every more-significant nibble are zero and its dp is off.
  function automatic logic lz_blanked(input frame_t f, input idx_t idx);
    logic all_zero;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx) && f.value[i*NIBBLE_W +: NIBBLE_W] != '0) begin
        all_zero = 1'b0;
      end
    end
    return (idx != '0) && all_zero && !f.dp[idx];
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// rtl/refresh_prescaler.sv - free-running divider that emits one tick every DIV enabled cycles
module refresh_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/hex_display_scan.sv
// rtl/hex_display_scan.sv - four-digit multiplexed hex display scanner with frame-synchronous data commit
module hex_display_scan
  import hex_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit FRAME_SYNC  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        lz_blank,
  input  logic        enable,
  output logic [3:0]  digit_out,
  output logic        dp_out,
  output logic [3:0]  an_n,
  output logic        blank,
  output logic        frame_start
);

  idx_t       r_idx;
  frame_t     r_disp;
  frame_t     r_pend;
  logic       r_pend_valid;
  logic       r_wrap_q;
  logic [3:0] r_an;
  logic [3:0] r_digit;
  logic       r_dp;
  logic       r_blank;
  logic       r_frame_start;

  logic       w_tick;
  logic       w_wrap;
  logic       w_dark;
  frame_t     w_in;

  refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (enable),
    .tick  (w_tick)
  );

  assign w_in   = '{value: value_in, dp: dp_in};
  assign w_wrap = w_tick && (r_idx == idx_t'(DIGITS - 1));
  assign w_dark = !enable || (lz_blank && lz_blanked(r_disp, r_idx));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx         <= '0;
      r_disp        <= '0;
      r_pend        <= '0;
      r_pend_valid  <= 1'b0;
      r_wrap_q      <= 1'b0;
      r_an          <= AN_OFF;
      r_digit       <= '0;
      r_dp          <= 1'b1;
      r_blank       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      if (w_tick) begin
        r_idx <= r_idx + 1'b1;
      end
      r_wrap_q      <= w_wrap;
      r_frame_start <= r_wrap_q;

      // A load landing on the wrap goes straight to the display so no frame is ever torn.
      if (!FRAME_SYNC) begin
        if (load) r_disp <= w_in;
      end else if (load && w_wrap) begin
        r_disp       <= w_in;
        r_pend_valid <= 1'b0;
      end else if (load) begin
        r_pend       <= w_in;
        r_pend_valid <= 1'b1;
      end else if (w_wrap && r_pend_valid) begin
        r_disp       <= r_pend;
        r_pend_valid <= 1'b0;
      end

      if (w_dark) begin
        r_an    <= AN_OFF;
        r_digit <= '0;
        r_dp    <= 1'b1;
        r_blank <= 1'b1;
      end else begin
        r_an    <= AN_OFF ^ (4'b0001 << r_idx);
        r_digit <= r_disp.value[r_idx*NIBBLE_W +: NIBBLE_W];
        r_dp    <= ~r_disp.dp[r_idx];
        r_blank <= 1'b0;
      end
    end
  end

  assign an_n        = r_an;
  assign digit_out   = r_digit;
  assign dp_out      = r_dp;
  assign blank       = r_blank;
  assign frame_start = r_frame_start;

endmodule
